// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer and the control unit:
// opcode values, one-hot ALU select constants, sequencer state type and
// the per-opcode latency lookup.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_SHR  = 4'd4;
  localparam logic [3:0] OP_SHRA = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_ROL  = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;
  localparam logic [3:0] OP_OR   = 4'd10;
  localparam logic [3:0] OP_NEG  = 4'd11;
  localparam logic [3:0] OP_NOT  = 4'd12;

  localparam int unsigned OPSEL_W = 13;

  localparam logic [OPSEL_W-1:0] OPSEL_ADD  = 13'h0001;
  localparam logic [OPSEL_W-1:0] OPSEL_SUB  = 13'h0002;
  localparam logic [OPSEL_W-1:0] OPSEL_MUL  = 13'h0004;
  localparam logic [OPSEL_W-1:0] OPSEL_DIV  = 13'h0008;
  localparam logic [OPSEL_W-1:0] OPSEL_SHR  = 13'h0010;
  localparam logic [OPSEL_W-1:0] OPSEL_SHRA = 13'h0020;
  localparam logic [OPSEL_W-1:0] OPSEL_SHL  = 13'h0040;
  localparam logic [OPSEL_W-1:0] OPSEL_ROR  = 13'h0080;
  localparam logic [OPSEL_W-1:0] OPSEL_ROL  = 13'h0100;
  localparam logic [OPSEL_W-1:0] OPSEL_AND  = 13'h0200;
  localparam logic [OPSEL_W-1:0] OPSEL_OR   = 13'h0400;
  localparam logic [OPSEL_W-1:0] OPSEL_NEG  = 13'h0800;
  localparam logic [OPSEL_W-1:0] OPSEL_NOT  = 13'h1000;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE,
    DONE
  } seq_state_t;

  // Cycles from ISSUE until the ALU result is valid; illegal opcodes use the base path.
  function automatic int unsigned op_latency(input logic [3:0] op,
                                             input int unsigned mul_lat,
                                             input int unsigned div_lat,
                                             input int unsigned base_lat);
    case (op)
      OP_MUL:  return mul_lat;
      OP_DIV:  return div_lat;
      default: return base_lat;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/result handshake bundle between the control unit (master) and
// the ALU operation sequencer (slave).
// Optional ALU_SEQ_FLAGS_EN adds res_zero/res_neg result flags.
interface alu_op_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_opcode;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_err;
`ifdef ALU_SEQ_FLAGS_EN
  logic        res_zero;
  logic        res_neg;

  modport master (
    output req_valid, req_opcode, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_hi, res_lo, res_err, res_zero, res_neg
  );

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, res_ready,
    output req_ready, res_valid, res_hi, res_lo, res_err, res_zero, res_neg
  );
`else
  modport master (
    output req_valid, req_opcode, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_hi, res_lo, res_err
  );

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, res_ready,
    output req_ready, res_valid, res_hi, res_lo, res_err
  );
`endif
endinterface

// File: rtl/alu_opcode_decoder.sv
// Combinational opcode to one-hot ALU select decoder with illegal-opcode flag.
// Shared with the control unit.
module alu_opcode_decoder
  import alu_pkg::*;
(
  input  logic [3:0]         opcode,
  output logic [OPSEL_W-1:0] op_sel,
  output logic               illegal
);

  // Map each legal opcode to its select bit; opcodes 13-15 select nothing.
  always_comb begin
    op_sel  = '0;
    illegal = 1'b0;
    case (opcode)
      OP_ADD:  op_sel = OPSEL_ADD;
      OP_SUB:  op_sel = OPSEL_SUB;
      OP_MUL:  op_sel = OPSEL_MUL;
      OP_DIV:  op_sel = OPSEL_DIV;
      OP_SHR:  op_sel = OPSEL_SHR;
      OP_SHRA: op_sel = OPSEL_SHRA;
      OP_SHL:  op_sel = OPSEL_SHL;
      OP_ROR:  op_sel = OPSEL_ROR;
      OP_ROL:  op_sel = OPSEL_ROL;
      OP_AND:  op_sel = OPSEL_AND;
      OP_OR:   op_sel = OPSEL_OR;
      OP_NEG:  op_sel = OPSEL_NEG;
      OP_NOT:  op_sel = OPSEL_NOT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: accepts one opcode/operand request, drives the
// ALU operand and select lines for the operation's latency, captures
// Zhigh/Zlo and returns them over a result handshake.
// Optional ALU_SEQ_FLAGS_EN adds registered res_zero/res_neg flags.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned MUL_LAT  = 2,
  parameter int unsigned DIV_LAT  = 34,
  parameter int unsigned BASE_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  alu_op_sequencer_if.slave  bus,
  output logic [31:0]        alu_y,
  output logic [31:0]        alu_b,
  output logic [OPSEL_W-1:0] alu_op_sel,
  output logic               alu_rst,
  input  logic [31:0]        alu_zhigh,
  input  logic [31:0]        alu_zlo
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ?
                                    ((MUL_LAT > BASE_LAT) ? MUL_LAT : BASE_LAT) :
                                    ((DIV_LAT > BASE_LAT) ? DIV_LAT : BASE_LAT);
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  seq_state_t         state;
  logic [CNT_W-1:0]   cnt;
  logic               err_q;
  logic [OPSEL_W-1:0] dec_sel;
  logic               dec_illegal;
  logic [CNT_W-1:0]   lat_m1;

  alu_opcode_decoder u_dec (
    .opcode  (bus.req_opcode),
    .op_sel  (dec_sel),
    .illegal (dec_illegal)
  );

  assign lat_m1 = CNT_W'(op_latency(bus.req_opcode, MUL_LAT, DIV_LAT, BASE_LAT) - 1);

  // Sequencer FSM with all handshake and ALU-side outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      err_q         <= 1'b0;
      alu_y         <= '0;
      alu_b         <= '0;
      alu_op_sel    <= '0;
      alu_rst       <= 1'b0;
      bus.req_ready <= 1'b1;
      bus.res_valid <= 1'b0;
      bus.res_hi    <= '0;
      bus.res_lo    <= '0;
      bus.res_err   <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      bus.res_zero  <= 1'b0;
      bus.res_neg   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            alu_y         <= bus.req_a;
            alu_b         <= bus.req_b;
            alu_op_sel    <= dec_sel;
            alu_rst       <= (bus.req_opcode == OP_DIV);
            err_q         <= dec_illegal;
            cnt           <= lat_m1;
            bus.req_ready <= 1'b0;
            state         <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          alu_rst <= 1'b0;
          if (cnt == '0) begin
            state <= CAPTURE;
          end else begin
            cnt   <= cnt - 1'b1;
            state <= WAIT;
          end
        end
        CAPTURE: begin
          // Select is still driven this cycle so the sample sees a settled ALU.
          bus.res_hi    <= err_q ? '0 : alu_zhigh;
          bus.res_lo    <= alu_zlo;
          bus.res_err   <= err_q;
          bus.res_valid <= 1'b1;
          alu_op_sel    <= '0;
`ifdef ALU_SEQ_FLAGS_EN
          bus.res_zero  <= (alu_zlo == '0);
          bus.res_neg   <= alu_zlo[31];
`endif
          state         <= DONE;
        end
        DONE: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            bus.res_err   <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: behavioural ALU with latency
// tracking, directed spec scenarios and randomized back-to-back traffic.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int unsigned MUL_LAT  = 2;
  localparam int unsigned DIV_LAT  = 34;
  localparam int unsigned BASE_LAT = 1;

  logic               clk = 1'b0;
  logic               reset;
  logic [31:0]        alu_y, alu_b, alu_zhigh, alu_zlo;
  logic [OPSEL_W-1:0] alu_op_sel;
  logic               alu_rst;
  int                 n_cmp = 0;
  int                 n_bad = 0;

  alu_op_sequencer_if bus();

  alu_op_sequencer #(
    .MUL_LAT  (MUL_LAT),
    .DIV_LAT  (DIV_LAT),
    .BASE_LAT (BASE_LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .alu_y      (alu_y),
    .alu_b      (alu_b),
    .alu_op_sel (alu_op_sel),
    .alu_rst    (alu_rst),
    .alu_zhigh  (alu_zhigh),
    .alu_zlo    (alu_zlo)
  );

  always #5 clk = ~clk;

  // Reference arithmetic of the ALU: {Zhigh, Zlo}
  function automatic logic [63:0] alu_fn(input int unsigned op, input logic [31:0] y, input logic [31:0] b);
    logic [63:0] p;
    logic [4:0]  s;
    s = b[4:0];
    case (op)
      0:  return {32'd0, y + b};
      1:  return {32'd0, y - b};
      2:  begin p = {32'd0, y} * {32'd0, b}; return p; end
      3:  return (b == 0) ? {y, 32'hFFFF_FFFF} : {y % b, y / b};
      4:  return {32'd0, y >> s};
      5:  return {32'd0, 32'($signed(y) >>> s)};
      6:  return {32'd0, y << s};
      7:  return {32'd0, (y >> s) | ((s == 0) ? 32'd0 : (y << (32 - int'(s))))};
      8:  return {32'd0, (y << s) | ((s == 0) ? 32'd0 : (y >> (32 - int'(s))))};
      9:  return {32'd0, y & b};
      10: return {32'd0, y | b};
      11: return {32'd0, -b};
      12: return {32'd0, ~b};
      default: return {32'd0, b};
    endcase
  endfunction

  function automatic int unsigned need_lat(input int unsigned op);
    return (op == 2) ? MUL_LAT : (op == 3) ? DIV_LAT : BASE_LAT;
  endfunction

  // Behavioural ALU: garbage until the select has been held long enough (DIV also needs its reset pulse)
  int unsigned alu_age = 0;
  logic        div_armed = 1'b0;
  always @(posedge clk) begin
    if (alu_op_sel == '0) begin
      alu_age   <= 0;
      div_armed <= 1'b0;
    end else begin
      alu_age <= alu_age + 1;
      if (alu_rst) div_armed <= 1'b1;
    end
  end

  always_comb begin
    int idx;
    logic [63:0] z;
    idx = -1;
    for (int i = 0; i < 13; i++) if (alu_op_sel[i]) idx = i;
    if (idx < 0) z = {32'd0, alu_b};
    else if (alu_age >= need_lat(idx) && (idx != 3 || div_armed)) z = alu_fn(idx, alu_y, alu_b);
    else z = 64'hBAD0_BAD1_BAD2_BAD3;
    alu_zhigh = z[63:32];
    alu_zlo   = z[31:0];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One complete transaction with full protocol checks. Starts and ends at a negedge.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input string tag, input logic use_exp, input logic [63:0] exp_in);
    logic [63:0] exp;
    logic        exp_err, exp_rst;
    logic [12:0] exp_sel, one;
    int          exp_lat, lat, w, rst_cnt, sel_bad;
    exp_err = (op > 4'd12);
    exp     = use_exp ? exp_in : (exp_err ? {32'd0, b} : alu_fn(op, a, b));
    one     = 13'd1;
    exp_sel = exp_err ? 13'd0 : (one << op);
    exp_rst = (op == 4'd3);
    exp_lat = need_lat(exp_err ? 0 : op) + 1;
    bus.res_ready = (hold == 0);
    w = 0;
    while (bus.req_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL %s idle req_ready: got %b want 1", tag, bus.req_ready); end
    bus.req_valid = 1'b1; bus.req_opcode = op; bus.req_a = a; bus.req_b = b;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    n_cmp++; if (alu_op_sel !== exp_sel) begin n_bad++; $display("FAIL %s issue op_sel: got %h want %h", tag, alu_op_sel, exp_sel); end
    n_cmp++; if (alu_y !== a || alu_b !== b) begin n_bad++; $display("FAIL %s issue operands: got %h/%h want %h/%h", tag, alu_y, alu_b, a, b); end
    n_cmp++; if (alu_rst !== exp_rst) begin n_bad++; $display("FAIL %s issue alu_rst: got %b want %b", tag, alu_rst, exp_rst); end
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL %s busy req_ready: got %b want 0", tag, bus.req_ready); end
    lat = 0; rst_cnt = 0; sel_bad = 0;
    while (bus.res_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
      if (alu_rst === 1'b1) rst_cnt++;
      if (bus.res_valid !== 1'b1 && alu_op_sel !== exp_sel) sel_bad++;
    end
    n_cmp++; if (lat != exp_lat) begin n_bad++; $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat); end
    n_cmp++; if (sel_bad != 0) begin n_bad++; $display("FAIL %s op_sel stable: got %0d bad cycles want 0", tag, sel_bad); end
    n_cmp++; if (rst_cnt != 0) begin n_bad++; $display("FAIL %s alu_rst extra: got %0d cycles want 0", tag, rst_cnt); end
    n_cmp++; if (alu_op_sel !== 13'd0) begin n_bad++; $display("FAIL %s op_sel after capture: got %h want 0", tag, alu_op_sel); end
    n_cmp++; if ({bus.res_hi, bus.res_lo} !== exp) begin n_bad++; $display("FAIL %s result: got %h want %h", tag, {bus.res_hi, bus.res_lo}, exp); end
    n_cmp++; if (bus.res_err !== exp_err) begin n_bad++; $display("FAIL %s res_err: got %b want %b", tag, bus.res_err, exp_err); end
`ifdef ALU_SEQ_FLAGS_EN
    n_cmp++; if (bus.res_zero !== (exp[31:0] == 0) || bus.res_neg !== exp[31]) begin
      n_bad++; $display("FAIL %s flags: got z%b n%b want z%b n%b", tag, bus.res_zero, bus.res_neg, exp[31:0] == 0, exp[31]);
    end
`endif
    for (int h = 0; h < hold; h++) begin
      bus.req_valid = 1'b1; bus.req_opcode = OP_ADD; bus.req_a = ~a; bus.req_b = ~b;
      @(negedge clk);
      n_cmp++;
      if (bus.res_valid !== 1'b1 || {bus.res_hi, bus.res_lo} !== exp || bus.req_ready !== 1'b0 || alu_y !== a || alu_op_sel !== 13'd0) begin
        n_bad++; $display("FAIL %s hold %0d: got v%b r%b res %h y %h want v1 r0 res %h y %h", tag, h, bus.res_valid, bus.req_ready, {bus.res_hi, bus.res_lo}, alu_y, exp, a);
      end
    end
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.res_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.res_err !== 1'b0) begin
      n_bad++; $display("FAIL %s consume: got v%b r%b e%b want v0 r1 e0", tag, bus.res_valid, bus.req_ready, bus.res_err);
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_opcode = '0; bus.req_a = '0; bus.req_b = '0; bus.res_ready = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.res_err !== 1'b0) begin
      n_bad++; $display("FAIL reset handshake: got r%b v%b e%b want r1 v0 e0", bus.req_ready, bus.res_valid, bus.res_err);
    end
    n_cmp++; if (alu_op_sel !== 13'd0 || alu_rst !== 1'b0 || alu_y !== 32'd0 || alu_b !== 32'd0) begin
      n_bad++; $display("FAIL reset alu side: got sel %h rst %b y %h b %h want all 0", alu_op_sel, alu_rst, alu_y, alu_b);
    end
    n_cmp++; if (bus.res_hi !== 32'd0 || bus.res_lo !== 32'd0) begin
      n_bad++; $display("FAIL reset result: got %h/%h want 0/0", bus.res_hi, bus.res_lo);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    do_op(OP_ADD, 32'd5, 32'd7, 0, "add", 1'b1, 64'd12);
    do_op(OP_MUL, 32'h0001_0000, 32'h0001_0000, 0, "mul", 1'b1, 64'h0000_0001_0000_0000);
    do_op(OP_DIV, 32'd17, 32'd5, 0, "div", 1'b1, {32'd2, 32'd3});
    do_op(4'd14, 32'h1234_5678, 32'h0000_00A5, 0, "illegal", 1'b1, 64'h0000_0000_0000_00A5);
    do_op(OP_ROL, 32'h8000_0001, 32'd1, 5, "rol_hold", 1'b1, 64'd3);
  endtask

  task automatic test_reset_mid_div();
    int w;
    bus.res_ready = 1'b1;
    w = 0;
    while (bus.req_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    bus.req_valid = 1'b1; bus.req_opcode = OP_DIV; bus.req_a = 32'd100; bus.req_b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++; if (alu_op_sel !== OPSEL_DIV) begin n_bad++; $display("FAIL middiv wait op_sel: got %h want %h", alu_op_sel, OPSEL_DIV); end
    reset = 1'b0;
    #1;
    n_cmp++; if (alu_op_sel !== 13'd0 || alu_rst !== 1'b0 || bus.req_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
      n_bad++; $display("FAIL middiv abort: got sel %h rst %b r%b v%b want 0 0 1 0", alu_op_sel, alu_rst, bus.req_ready, bus.res_valid);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_op(OP_ADD, 32'd40, 32'd2, 0, "after_reset_add", 1'b1, 64'd42);
  endtask

  task automatic test_back_to_back();
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if (op == OP_DIV && b == 0) b = 32'd1;
      do_op(op, a, b, $urandom_range(0, 3), "rand", 1'b0, 64'd0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_div();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
